bus_irq_controller: RTL
=======================

// Module: bus_irq_controller
// PURPOSE
// Memory-mapped interrupt controller on the RV32 CPU bus. It collects NUM_SRC
// external interrupt sources and latches them into pending bits. It exposes
// enable, edge-select, clear and ID registers to the CPU and drives the CPU's
// single irq_i input. Downstream of the CPU address/we/data outputs; its read
// data feeds one slot of the CPU data_reg input mux.
// PARAMETERS
// BASE_ADDR   32'h0000_9100  byte base address of the 5-word register block
// NUM_SRC     8              number of interrupt sources, 1..32
// ADDR_WIDTH  32             bus address width (matches package address_width)
// DATA_WIDTH  32             bus data width (matches package data_width)
// PORTS
// clk_i      in   1           system clock; all logic on rising edge
// reset_i    in   1           synchronous, active-high reset
// address_i  in   ADDR_WIDTH  CPU bus address
// we_i       in   1           CPU write strobe, single-cycle, qualifies data_i
// data_i     in   DATA_WIDTH  CPU write data
// data_o     out  DATA_WIDTH  registered read data to CPU read mux
// irq_src_i  in   NUM_SRC     asynchronous interrupt sources, active-high
// irq_o      out  1           interrupt request to CPU irq_i, registered
// BEHAVIOUR
// - Register map, byte offsets from BASE_ADDR; unimplemented bits read 0:
//   0x00 PENDING  RO   pending[NUM_SRC-1:0]
//   0x04 ENABLE   RW   per-source mask, 1 = enabled
//   0x08 EDGE     RW   per-source mode: 1 = rising-edge latched, 0 = level
//   0x0C CLEAR    WO   write 1 clears pending bit (edge mode only); reads 0
//   0x10 ID       RO   index of lowest-numbered pending&enabled source;
//                      32'hFFFF_FFFF when none
// - Reset (reset_i high at a clock edge): pending, ENABLE, EDGE, sync flops,
//   prev flops, data_o and irq_o all 0. Reset is honoured mid-operation with
//   no residual state. A source still high after reset in edge mode does not
//   latch; prev is 0, so it latches only if sync2 rises after reset deasserts.
// - Synchronisation: sync1 <= irq_src_i; sync2 <= sync1; prev <= sync2;
//   rise = sync2 & ~prev.
// - Edge mode: pending[i] <= (pending[i] & ~clr[i]) | rise[i], where clr[i] is
//   the write to CLEAR with data_i[i] = 1. Set wins over a same-cycle clear.
// - Level mode: pending[i] <= sync2[i]. CLEAR has no effect on it.
// - Changing EDGE[i] from 0 to 1 keeps the current pending value. The next
//   update then follows edge rules.
// - irq_o <= |(pending & ENABLE). Latency: a source high at sampling edge k
//   sets pending after edge k+2 and irq_o after edge k+3. A disabled pending
//   bit stays pending; setting ENABLE raises irq_o one cycle after the write.
// - Writes: decoded when we_i = 1 and address_i equals BASE_ADDR + 0x04, 0x08
//   or 0x0C. Writes to 0x00, 0x10 or any undecoded address are ignored. Bits
//   at index >= NUM_SRC are ignored.
// - Reads: data_o <= value at address_i every cycle we_i = 0, so data_o is
//   valid one cycle after the address. The value is pre-update state of that
//   cycle. Undecoded addresses give data_o = 0. During a write cycle data_o
//   is 0.
// - ID is combinational from the current pending & ENABLE and is registered
//   into data_o like the other registers. The lowest index wins.
// - No state machine beyond the per-source pending latch. All arithmetic is
//   bitwise; the ID priority encoder is a for-loop over NUM_SRC.
// TESTING
// - Reset, write ENABLE=0xFF, EDGE=0xFF, pulse src[3] for 1 clk -> PENDING
//   reads 0x08, ID reads 3, irq_o high 3 clks after the sampling edge.
// - Write CLEAR=0x08 -> PENDING reads 0, irq_o low the cycle after pending
//   drops; a CLEAR write of 0x08 coincident with a new rise[3] leaves
//   PENDING=0x08.
// - EDGE=0, ENABLE=0x01, hold src[0] high then low -> PENDING follows the
//   level with 2-clk lag; a CLEAR write of 0x01 while src[0] is high leaves
//   PENDING=0x01.
// - ENABLE=0, pulse src[5] and src[2] -> irq_o stays 0, ID=0xFFFFFFFF;
//   write ENABLE=0x24 -> irq_o high next clk, ID=2.
// - Assert reset_i mid-operation with PENDING=0xFF and irq_o=1 -> all
//   registers read 0 and irq_o=0 the cycle after. A read of BASE_ADDR+0x20
//   -> data_o=0.
// - Write to PENDING (0x00) with 0xFF -> no change; NUM_SRC=4 build: write
//   ENABLE=0xFF -> reads 0x0F.

Source files
------------

// File: rtl/bus_irq_controller_if.sv
// Bus interface between the RV32 CPU and the interrupt controller.
//   address : byte address from the CPU
//   we      : single-cycle write strobe, qualifies wdata
//   wdata   : write data from the CPU
//   rdata   : registered read data back to the CPU read mux
// Modports: master (CPU side), slave (peripheral side).
interface bus_irq_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output address, output we, output wdata, input rdata);
  modport slave  (input address, input we, input wdata, output rdata);
endinterface

// File: rtl/bus_irq_controller.sv
// Memory-mapped interrupt controller. Synchronises NUM_SRC asynchronous sources,
// latches them into pending bits (edge or level mode per source) and drives a
// single registered interrupt request to the CPU.
// Ports:
//   clk_i     : system clock, rising edge
//   reset_i   : synchronous active-high reset
//   bus       : CPU bus slave (address, we, wdata in; registered rdata out)
//   irq_src_i : asynchronous interrupt sources, active-high
//   irq_o     : registered interrupt request to the CPU
// Register map (byte offsets): 0x00 PENDING RO, 0x04 ENABLE RW, 0x08 EDGE RW,
// 0x0C CLEAR WO (reads 0), 0x10 ID RO (lowest pending&enabled, all-ones if none).
module bus_irq_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_9100,
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bus_irq_controller_if.slave       bus,
  input  logic [NUM_SRC-1:0]        irq_src_i,
  output logic                      irq_o
);

  localparam logic [ADDR_WIDTH-1:0] AddrPending = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] AddrEnable  = BASE_ADDR + ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] AddrEdge    = BASE_ADDR + ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] AddrClear   = BASE_ADDR + ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] AddrId      = BASE_ADDR + ADDR_WIDTH'(32'h10);

  logic [NUM_SRC-1:0]    sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0]    pending_q, pending_d;
  logic [NUM_SRC-1:0]    enable_q, edge_mode_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q;

  logic [NUM_SRC-1:0]    rise, clr, active;
  logic [DATA_WIDTH-1:0] id_val;
  logic                  wr_enable, wr_edge, wr_clear;

  assign wr_enable = bus.we && (bus.address == AddrEnable);
  assign wr_edge   = bus.we && (bus.address == AddrEdge);
  assign wr_clear  = bus.we && (bus.address == AddrClear);

  assign rise   = sync2_q & ~prev_q;
  assign clr    = wr_clear ? bus.wdata[NUM_SRC-1:0] : '0;
  assign active = pending_q & enable_q;

  // Edge mode: a rise in the same cycle as a clear wins. Level mode tracks sync2.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (edge_mode_q[i]) pending_d[i] = (pending_q[i] & ~clr[i]) | rise[i];
      else                pending_d[i] = sync2_q[i];
    end
  end

  // Scan high to low so the lowest active index is the last one written.
  always_comb begin
    id_val = '1;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) id_val = DATA_WIDTH'(i);
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!bus.we) begin
      case (bus.address)
        AddrPending: rdata_d = DATA_WIDTH'(pending_q);
        AddrEnable:  rdata_d = DATA_WIDTH'(enable_q);
        AddrEdge:    rdata_d = DATA_WIDTH'(edge_mode_q);
        AddrId:      rdata_d = id_val;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      edge_mode_q <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q   <= irq_src_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      if (wr_enable) enable_q    <= bus.wdata[NUM_SRC-1:0];
      if (wr_edge)   edge_mode_q <= bus.wdata[NUM_SRC-1:0];
      rdata_q   <= rdata_d;
      irq_q     <= |active;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq_o     = irq_q;

endmodule
